// File: rtl/rtc_bcd_time_loader_pkg.sv
// Shared definitions for the RTC BCD time loader: FSM state encoding and the
// range limits used when validating a frame read back from the RTC.
// No ports; imported by the loader top and its interface users.
package rtc_bcd_time_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAP_SS = 3'd1,
    ST_CAP_MM = 3'd2,
    ST_CAP_HH = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  localparam logic [4:0] MAX_HH      = 5'd23;
  localparam logic [5:0] MAX_MIN_SEC = 6'd59;
  localparam int         HH_12H_BIT  = 6;

  // Largest legal tens digit for minutes/seconds and for hours.
  localparam logic [2:0] MAX_MS_TENS = 3'd5;
  localparam logic [1:0] MAX_HH_TENS = 2'd2;

endpackage

// File: rtl/rtc_bcd_time_loader_if.sv
// Bus between the RTC read sequencer (master) and the BCD time loader (slave).
// Latency/backpressure: none of its own; rd_valid is a push with no ready.
// Signals: start, rd_valid, rd_data[7:0] toward the loader; busy, load_pulse,
//   hh_bin[4:0], mm_bin[5:0], ss_bin[5:0], bcd_err back to the sequencer/counters.
interface rtc_bcd_time_loader_if;

  logic       start;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       load_pulse;
  logic [4:0] hh_bin;
  logic [5:0] mm_bin;
  logic [5:0] ss_bin;
  logic       bcd_err;

  modport master (
    output start, rd_valid, rd_data,
    input  busy, load_pulse, hh_bin, mm_bin, ss_bin, bcd_err
  );

  modport slave (
    input  start, rd_valid, rd_data,
    output busy, load_pulse, hh_bin, mm_bin, ss_bin, bcd_err
  );

endinterface

// File: rtl/bcd2bin_2dig.sv
// Two-digit BCD to binary converter; purely combinational, zero latency,
// no flow control. Ports: i_tens[3:0], i_units[3:0] -> o_bin[6:0], o_digit_ok.
// o_digit_ok only qualifies the units digit; tens limits differ per field and
// are checked by the caller. o_bin wraps for tens > 11, which the caller rejects.
module bcd2bin_2dig (
  input  logic [3:0] i_tens,
  input  logic [3:0] i_units,
  output logic [6:0] o_bin,
  output logic       o_digit_ok
);

  logic [6:0] w_tens;
  logic [6:0] w_units;

  assign w_tens  = {3'b000, i_tens};
  assign w_units = {3'b000, i_units};

  // tens*10 as shift-and-add: 8*tens + 2*tens.
  assign o_bin      = (w_tens << 3) + (w_tens << 1) + w_units;
  assign o_digit_ok = (i_units <= 4'd9);

endmodule

// File: rtl/rtc_bcd_time_loader.sv
// Captures the SS, MM, HH BCD bytes read from the RTC, validates them and
// loads binary time into the counters. Latency: load_pulse/bcd_err appear the
// 2nd clk after the HH byte is accepted. Backpressure: none; bytes are pushed
// with rd_valid, a per-byte timeout aborts a stalled frame with bcd_err.
// Ports: i_clk, i_rst (async, active high), io_bus (slave side of the bus).
module rtc_bcd_time_loader
  import rtc_bcd_time_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rtc_bcd_time_loader_if.slave   io_bus
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_nxt;

  logic [7:0] r_ss;
  logic [7:0] r_mm;
  logic [7:0] r_hh;

  logic       r_busy;
  logic       r_load;
  logic       r_err;
  logic [4:0] r_hh_bin;
  logic [5:0] r_mm_bin;
  logic [5:0] r_ss_bin;

  logic w_cap_ss;
  logic w_cap_mm;
  logic w_cap_hh;
  logic w_load;
  logic w_err;
  logic w_to_hit;

  logic [6:0] w_ss_bin;
  logic [6:0] w_mm_bin;
  logic [6:0] w_hh_bin;
  logic       w_ss_dig_ok;
  logic       w_mm_dig_ok;
  logic       w_hh_dig_ok;
  logic       w_ss_ok;
  logic       w_mm_ok;
  logic       w_hh_ok;
  logic       w_frame_ok;

  // Bit 7 of every byte carries RTC control flags that are not part of the time.
  logic [2:0] w_unused;
  assign w_unused = {r_ss[7], r_mm[7], r_hh[7]};

  // ---------------------------------------------------------------- convert
  bcd2bin_2dig u_ss_conv (
    .i_tens     ({1'b0, r_ss[6:4]}),
    .i_units    (r_ss[3:0]),
    .o_bin      (w_ss_bin),
    .o_digit_ok (w_ss_dig_ok)
  );

  bcd2bin_2dig u_mm_conv (
    .i_tens     ({1'b0, r_mm[6:4]}),
    .i_units    (r_mm[3:0]),
    .o_bin      (w_mm_bin),
    .o_digit_ok (w_mm_dig_ok)
  );

  bcd2bin_2dig u_hh_conv (
    .i_tens     ({2'b00, r_hh[5:4]}),
    .i_units    (r_hh[3:0]),
    .o_bin      (w_hh_bin),
    .o_digit_ok (w_hh_dig_ok)
  );

  assign w_ss_ok = w_ss_dig_ok && (r_ss[6:4] <= MAX_MS_TENS)
                && (w_ss_bin <= {1'b0, MAX_MIN_SEC});
  assign w_mm_ok = w_mm_dig_ok && (r_mm[6:4] <= MAX_MS_TENS)
                && (w_mm_bin <= {1'b0, MAX_MIN_SEC});
  // A set 12h-mode bit means the RTC is not in 24h format: reject the frame.
  assign w_hh_ok = w_hh_dig_ok && !r_hh[HH_12H_BIT] && (r_hh[5:4] <= MAX_HH_TENS)
                && (w_hh_bin <= {2'b00, MAX_HH});

  assign w_frame_ok = w_ss_ok && w_mm_ok && w_hh_ok;

  // Terminal count is one below TIMEOUT_CYC because the check runs on the
  // pre-increment value: the error fires on the TIMEOUT_CYC-th idle cycle.
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to_cnt;
    w_cap_ss    = 1'b0;
    w_cap_mm    = 1'b0;
    w_cap_hh    = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_state_nxt = ST_CAP_SS;
          w_to_nxt    = '0;
        end
      end

      ST_CAP_SS, ST_CAP_MM, ST_CAP_HH: begin
        if (io_bus.rd_valid) begin
          w_to_nxt = '0;
          case (r_state)
            ST_CAP_SS: begin w_cap_ss = 1'b1; w_state_nxt = ST_CAP_MM; end
            ST_CAP_MM: begin w_cap_mm = 1'b1; w_state_nxt = ST_CAP_HH; end
            default:   begin w_cap_hh = 1'b1; w_state_nxt = ST_CHECK;  end
          endcase
        end else if (w_to_hit) begin
          w_err       = 1'b1;
          w_to_nxt    = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end

      ST_CHECK: begin
        w_load      = w_frame_ok;
        w_err       = !w_frame_ok;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ss     <= '0;
      r_mm     <= '0;
      r_hh     <= '0;
      r_busy   <= 1'b0;
      r_load   <= 1'b0;
      r_err    <= 1'b0;
      r_hh_bin <= '0;
      r_mm_bin <= '0;
      r_ss_bin <= '0;
    end else begin
      if (w_cap_ss) r_ss <= io_bus.rd_data;
      if (w_cap_mm) r_mm <= io_bus.rd_data;
      if (w_cap_hh) r_hh <= io_bus.rd_data;

      r_busy <= (w_state_nxt != ST_IDLE);
      r_load <= w_load;
      r_err  <= w_err;

      // Outputs only move on a good frame; a rejected frame leaves the last
      // good time visible.
      if (w_load) begin
        r_hh_bin <= w_hh_bin[4:0];
        r_mm_bin <= w_mm_bin[5:0];
        r_ss_bin <= w_ss_bin[5:0];
      end
    end
  end

  assign io_bus.busy       = r_busy;
  assign io_bus.load_pulse = r_load;
  assign io_bus.bcd_err    = r_err;
  assign io_bus.hh_bin     = r_hh_bin;
  assign io_bus.mm_bin     = r_mm_bin;
  assign io_bus.ss_bin     = r_ss_bin;

endmodule
